core_fetch: RTL and testbench
=============================

CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 Ports SHALL be (clock and reset first):
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- next_pc  in  64  redirect/sequential target from branch resolution
- flush  in  1  discard in-flight/held fetch and load next_pc
- stall  in  1  hazard hold for the IF/ID register
- pc4  out  64  current fetch PC + 4, fed to branch resolution
- imem_req  out  1  instruction-memory request, held until imem_ack
- imem_addr  out  64  word-aligned fetch address, stable while imem_req=1
- imem_ack  in  1  response valid this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- IF_regs  out  IF_regs_t  IF/ID register {pc, pc4, inst, valid}
- fetch_busy  out  1  high when state is DRAIN or HOLD

Function
REQ-002 Fetch PC register `pc` SHALL be held internally; pc4 = pc + 4, modulo 2^64.
REQ-003 imem_addr SHALL be {addr[63:2], 2'b00}; addr = drain_addr in DRAIN, otherwise pc.
REQ-004 imem_req SHALL be 1 only in states REQ and DRAIN.
REQ-005 States SHALL be:
- IDLE: no request outstanding
- REQ: request at pc outstanding
- DRAIN: stale request outstanding
- HOLD: response captured, waiting for stall release
REQ-006 IDLE SHALL go to REQ next cycle; flush in IDLE sets pc <= next_pc.
REQ-007 REQ transitions:
- ack & !flush & !stall: IF_regs <= {pc, pc4, imem_rdata, 1}; pc <= next_pc; stay REQ.
- ack & !flush & stall: hold_inst <= imem_rdata; pc unchanged; go to HOLD.
- ack & flush: discard data; IF_regs.valid <= 0; pc <= next_pc; stay REQ.
- !ack & flush: drain_addr <= pc; pc <= next_pc; IF_regs.valid <= 0; go to DRAIN.
- !ack & !flush: no change.
REQ-008 DRAIN transitions:
- ack: discard data; go to REQ.
- flush: pc <= next_pc; IF_regs.valid <= 0; remain in DRAIN until ack.
REQ-009 HOLD transitions:
- flush: discard hold; IF_regs.valid <= 0; pc <= next_pc; go to REQ.
- !flush & !stall: IF_regs <= {pc, pc4, hold_inst, 1}; pc <= next_pc; go to REQ.
REQ-010 Priority SHALL be reset > flush > stall; with stall=1 and no flush, IF_regs SHALL hold its value.
REQ-011 Minimum latency SHALL be one fetched instruction per cycle while imem_ack is high every cycle.
REQ-012 Results for a stale address (DRAIN ack, or flush coincident with ack) SHALL never reach IF_regs.

Reset
REQ-013 On reset: pc <= 0, state <= IDLE, IF_regs <= all zero, drain_addr/hold_inst <= 0, counters <= 0.
REQ-014 imem_req SHALL be 0 in the cycle after reset; an outstanding request is abandoned, and its late ack SHALL be ignored while in IDLE.

Configuration
REQ-015 With CORE_FETCH_PERF_EN defined:
- ports perf_fetched (out, 64) and perf_discarded (out, 64) SHALL exist.
- perf_fetched increments per ack loaded into IF_regs or captured in HOLD.
- perf_discarded increments per ack discarded (REQ-007 flush case, REQ-008) and per held word dropped by flush (REQ-009).
REQ-016 Without CORE_FETCH_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-017 IF_regs_t and fetch_state_t (IDLE/REQ/DRAIN/HOLD) SHALL live in package structures.
REQ-018 Perf counters SHALL be a sub-module core_fetch_perf, instantiated only under CORE_FETCH_PERF_EN.

Verification
REQ-019 Reset, ack every cycle, next_pc=pc4 -> IF_regs.pc = 0, 4, 8, 12 on consecutive cycles, valid=1.
REQ-020 Flush with next_pc=0x100 while REQ has no ack, ack 2 cycles later -> state DRAIN, that data dropped, next request addr 0x100.
REQ-021 stall=1 when ack arrives with inst 0x24020005 -> HOLD, imem_req=0, IF_regs unchanged; stall=0 -> IF_regs.inst = 0x24020005.
REQ-022 flush and stall together in HOLD with next_pc=0x80 -> hold dropped, IF_regs.valid=0, next imem_addr=0x80.
REQ-023 next_pc=0xFFFF_FFFF_FFFF_FFFC -> pc4=0; next_pc=0x102 -> imem_addr=0x100.
REQ-024 With CORE_FETCH_PERF_EN: 5 accepted fetches + 1 DRAIN discard -> perf_fetched=5, perf_discarded=1; reset mid-request -> both 0 and the late ack is ignored.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared types for the instruction-fetch stage: IF/ID register layout and fetch FSM states.
package structures;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } IF_regs_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [63:0] PC_STEP = 64'd4;

  function automatic logic [63:0] word_align(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_fetch_perf.sv
// Fetch performance counters: words delivered vs. words thrown away.
module core_fetch_perf
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc_fetched,
  input  logic        i_inc_discarded,
  output logic [63:0] o_fetched,
  output logic [63:0] o_discarded
);

  logic [63:0] r_fetched;
  logic [63:0] r_discarded;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetched   <= '0;
      r_discarded <= '0;
    end else begin
      if (i_inc_fetched)   r_fetched   <= r_fetched + 64'd1;
      if (i_inc_discarded) r_discarded <= r_discarded + 64'd1;
    end
  end

  assign o_fetched   = r_fetched;
  assign o_discarded = r_discarded;

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: one outstanding imem request, flush drain and stall hold.
// Define CORE_FETCH_PERF_EN to add perf_fetched/perf_discarded counters.
module core_fetch
  import structures::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [63:0] pc4,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output IF_regs_t    IF_regs,
  output logic        fetch_busy
`ifdef CORE_FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_discarded
`endif
);

  fetch_state_t r_state, w_state_nxt;
  logic [63:0]  r_pc, w_pc_nxt;
  logic [63:0]  r_drain_addr, w_drain_nxt;
  logic [31:0]  r_hold_inst, w_hold_nxt;
  IF_regs_t     r_if, w_if_nxt;
  logic [63:0]  w_pc4;

  assign w_pc4 = r_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_drain_addr <= '0;
      r_hold_inst  <= '0;
      r_if         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_nxt;
      r_hold_inst  <= w_hold_nxt;
      r_if         <= w_if_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drain_nxt = r_drain_addr;
    w_hold_nxt  = r_hold_inst;
    w_if_nxt    = r_if;
    case (r_state)
      IDLE: begin
        // An ack here belongs to a request abandoned by reset; it is ignored.
        w_state_nxt = REQ;
        if (flush) w_pc_nxt = next_pc;
      end
      REQ: begin
        if (imem_ack) begin
          if (flush) begin
            w_if_nxt.valid = 1'b0;
            w_pc_nxt       = next_pc;
          end else if (stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = HOLD;
          end else begin
            w_if_nxt = '{pc: r_pc, pc4: w_pc4, inst: imem_rdata, valid: 1'b1};
            w_pc_nxt = next_pc;
          end
        end else if (flush) begin
          w_drain_nxt    = r_pc;
          w_pc_nxt       = next_pc;
          w_if_nxt.valid = 1'b0;
          w_state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (flush) begin
          w_pc_nxt       = next_pc;
          w_if_nxt.valid = 1'b0;
        end
        if (imem_ack) w_state_nxt = REQ;
      end
      HOLD: begin
        if (flush) begin
          w_if_nxt.valid = 1'b0;
          w_pc_nxt       = next_pc;
          w_state_nxt    = REQ;
        end else if (!stall) begin
          w_if_nxt    = '{pc: r_pc, pc4: w_pc4, inst: r_hold_inst, valid: 1'b1};
          w_pc_nxt    = next_pc;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pc4        = w_pc4;
  assign imem_req   = (r_state == REQ) || (r_state == DRAIN);
  assign imem_addr  = word_align((r_state == DRAIN) ? r_drain_addr : r_pc);
  assign IF_regs    = r_if;
  assign fetch_busy = (r_state == DRAIN) || (r_state == HOLD);

`ifdef CORE_FETCH_PERF_EN
  logic w_inc_fetched, w_inc_discarded;

  assign w_inc_fetched   = (r_state == REQ) && imem_ack && !flush;
  assign w_inc_discarded = ((r_state == REQ) && imem_ack && flush) ||
                           ((r_state == DRAIN) && imem_ack) ||
                           ((r_state == HOLD) && flush);

  core_fetch_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_inc_fetched  (w_inc_fetched),
    .i_inc_discarded(w_inc_discarded),
    .o_fetched      (perf_fetched),
    .o_discarded    (perf_discarded)
  );
`endif

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: streaming, flush/drain, stall/hold, wraparound, reset abandon.
module tb_core_fetch;
  import structures::*;

  logic        clk = 1'b0;
  logic        reset, flush, stall, imem_ack;
  logic [63:0] next_pc;
  logic [31:0] imem_rdata;
  logic [63:0] pc4, imem_addr;
  logic        imem_req, fetch_busy;
  IF_regs_t    IF_regs;
`ifdef CORE_FETCH_PERF_EN
  logic [63:0] perf_fetched, perf_discarded;
`endif

  int checks   = 0;
  int failures = 0;

  core_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .next_pc   (next_pc),
    .flush     (flush),
    .stall     (stall),
    .pc4       (pc4),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .IF_regs   (IF_regs),
    .fetch_busy(fetch_busy)
`ifdef CORE_FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    next_pc = '0; imem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    // reset state: IDLE, no request, IF/ID cleared
    chk("rst_req",   imem_req, 0);
    chk("rst_busy",  fetch_busy, 0);
    chk("rst_if_pc", IF_regs.pc, 0);
    chk("rst_if_pc4", IF_regs.pc4, 0);
    chk("rst_if_inst", IF_regs.inst, 0);
    chk("rst_if_valid", IF_regs.valid, 0);
    chk("rst_pc4",   pc4, 64'h4);
    tick();
    chk("req_after_idle", imem_req, 1);
    chk("addr0", imem_addr, 0);

    // back-to-back acks, sequential next_pc
    for (int i = 0; i < 4; i++) begin
      next_pc    = 64'((i + 1) * 4);
      imem_rdata = 32'h1000 + 32'(i);
      imem_ack   = 1'b1;
      tick();
      chk("seq_if_pc",    IF_regs.pc, 64'(i * 4));
      chk("seq_if_pc4",   IF_regs.pc4, 64'((i + 1) * 4));
      chk("seq_if_inst",  IF_regs.inst, 64'(32'h1000 + 32'(i)));
      chk("seq_if_valid", IF_regs.valid, 1);
      chk("seq_addr",     imem_addr, 64'((i + 1) * 4));
    end

    // flush with no ack -> DRAIN on stale address 0x10
    imem_ack = 1'b0; flush = 1'b1; next_pc = 64'h100;
    tick();
    chk("drain_busy",  fetch_busy, 1);
    chk("drain_req",   imem_req, 1);
    chk("drain_addr",  imem_addr, 64'h10);
    chk("drain_valid", IF_regs.valid, 0);
    chk("drain_pc4",   pc4, 64'h104);
    flush = 1'b0; next_pc = 64'h999;
    tick();
    chk("drain_wait_busy", fetch_busy, 1);
    chk("drain_wait_addr", imem_addr, 64'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("drain_done_busy",  fetch_busy, 0);
    chk("drain_done_addr",  imem_addr, 64'h100);
    chk("drain_done_valid", IF_regs.valid, 0);

    // stall on ack -> HOLD, then release
    stall = 1'b1; imem_rdata = 32'h24020005; next_pc = 64'h104;
    tick();
    chk("hold_req",   imem_req, 0);
    chk("hold_busy",  fetch_busy, 1);
    chk("hold_valid", IF_regs.valid, 0);
    chk("hold_inst_kept", IF_regs.inst, 64'h1003);
    imem_ack = 1'b0;
    tick();
    chk("hold_stay_req", imem_req, 0);
    stall = 1'b0;
    tick();
    chk("rel_inst",  IF_regs.inst, 64'h24020005);
    chk("rel_pc",    IF_regs.pc, 64'h100);
    chk("rel_pc4",   IF_regs.pc4, 64'h104);
    chk("rel_valid", IF_regs.valid, 1);
    chk("rel_addr",  imem_addr, 64'h104);
    chk("rel_req",   imem_req, 1);

    // flush+stall in HOLD drops the held word
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h11111111; next_pc = 64'h108;
    tick();
    chk("hold2_busy", fetch_busy, 1);
    imem_ack = 1'b0; flush = 1'b1; next_pc = 64'h80;
    tick();
    chk("hflush_valid", IF_regs.valid, 0);
    chk("hflush_addr",  imem_addr, 64'h80);
    chk("hflush_req",   imem_req, 1);
    chk("hflush_busy",  fetch_busy, 0);
    flush = 1'b0; stall = 1'b0;

    // pc wraparound and word alignment of imem_addr
    imem_ack = 1'b1; imem_rdata = 32'h22222222; next_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("wrap_if_pc", IF_regs.pc, 64'h80);
    chk("wrap_pc4",   pc4, 0);
    chk("wrap_addr",  imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_rdata = 32'h33333333; next_pc = 64'h102;
    tick();
    chk("wrap_if_pc2",  IF_regs.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_if_pc4",  IF_regs.pc4, 0);
    chk("align_addr",   imem_addr, 64'h100);
    chk("align_pc4",    pc4, 64'h106);
    imem_ack = 1'b0;

    // 5 accepted fetches then one drain discard
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_pc = 64'((i + 1) * 4);
      imem_rdata = 32'h5000 + 32'(i);
      tick();
    end
    chk("p5_if_pc", IF_regs.pc, 64'h10);
    imem_ack = 1'b0; flush = 1'b1; next_pc = 64'h200;
    tick();
    flush = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("p5_addr", imem_addr, 64'h200);
`ifdef CORE_FETCH_PERF_EN
    chk("perf_fetched",   perf_fetched, 5);
    chk("perf_discarded", perf_discarded, 1);
`endif

    // reset mid-request; late ack arriving in IDLE is ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_req",   imem_req, 0);
    chk("mrst_valid", IF_regs.valid, 0);
`ifdef CORE_FETCH_PERF_EN
    chk("mrst_perf_f", perf_fetched, 0);
    chk("mrst_perf_d", perf_discarded, 0);
`endif
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0; next_pc = 64'h40;
    tick();
    imem_ack = 1'b0;
    chk("late_req",   imem_req, 1);
    chk("late_addr",  imem_addr, 0);
    chk("late_valid", IF_regs.valid, 0);
`ifdef CORE_FETCH_PERF_EN
    chk("late_perf_f", perf_fetched, 0);
    chk("late_perf_d", perf_discarded, 0);
`endif
    tick();
    chk("late_valid2", IF_regs.valid, 0);
    chk("late_addr2",  imem_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
